// File: rtl/thread_sched_if.sv
// rtl/thread_sched_if.sv - fetch, redirect, spawn and thread-control signals of thread_sched
interface thread_sched_if #(
  parameter int N_TRD = 8,
  parameter int TRD_W = $clog2(N_TRD)
);
  logic                     stall;
  logic                     jmp_en;
  logic [TRD_W-1:0]         jmp_trd;
  logic [31:0]              jmp_pc;
  logic                     miss_en;
  logic [TRD_W-1:0]         miss_trd;
  logic [31:0]              miss_pc;
  logic                     miss_clr;
  logic [TRD_W-1:0]         miss_clr_trd;
  logic                     spawn_req;
  logic [31:0]              spawn_pc;
  logic [TRD_W-1:0]         spawn_parent;
  logic                     kill;
  logic                     sleep;
  logic                     wake;
  logic [TRD_W-1:0]         obj_trd;

  logic                     if_vld;
  logic [TRD_W-1:0]         if_trd;
  logic [31:0]              if_pc;
  logic                     spawn_ok;
  logic [TRD_W-1:0]         spawn_id;
  logic [N_TRD-1:0]         valid_trd;
  logic [N_TRD-1:0]         run_trd;
  logic [N_TRD-1:0]         park_trd;
  logic [N_TRD*N_TRD-1:0]   child_mask;
  logic                     trd_full;
  logic                     trd_of;

  modport master (
    output stall, jmp_en, jmp_trd, jmp_pc, miss_en, miss_trd, miss_pc,
           miss_clr, miss_clr_trd, spawn_req, spawn_pc, spawn_parent,
           kill, sleep, wake, obj_trd,
    input  if_vld, if_trd, if_pc, spawn_ok, spawn_id, valid_trd, run_trd,
           park_trd, child_mask, trd_full, trd_of
  );

  modport slave (
    input  stall, jmp_en, jmp_trd, jmp_pc, miss_en, miss_trd, miss_pc,
           miss_clr, miss_clr_trd, spawn_req, spawn_pc, spawn_parent,
           kill, sleep, wake, obj_trd,
    output if_vld, if_trd, if_pc, spawn_ok, spawn_id, valid_trd, run_trd,
           park_trd, child_mask, trd_full, trd_of
  );
endinterface

// File: rtl/thread_sched.sv
// rtl/thread_sched.sv - hardware thread scheduler: fetch slot selection, spawn/kill, park and sleep
module thread_sched #(
  parameter int          N_TRD    = 8,
  parameter int          TRD_W    = $clog2(N_TRD),
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MODE     = 0
) (
  input  logic          clk,
  input  logic          rst,
  thread_sched_if.slave bus
);

  logic [N_TRD-1:0]       valid_q, valid_d;
  logic [N_TRD-1:0]       run_q, run_d;
  logic [N_TRD-1:0]       park_q, park_d;
  logic [31:0]            pc_q [N_TRD];
  logic [31:0]            pc_d [N_TRD];
  logic [N_TRD*N_TRD-1:0] child_q, child_d;
  logic [TRD_W-1:0]       last_q, last_d;
  logic                   of_q, of_d;
  logic                   halt_q, halt_d;

  logic [N_TRD-1:0]       eligible;
  logic [TRD_W-1:0]       sel_trd;
  logic [TRD_W-1:0]       rr_trd;
  logic [TRD_W-1:0]       free_id;
  logic                   full;
  logic                   fire;
  logic                   spawn_ok;
  logic                   do_kill, do_kill0, do_sleep, do_wake, do_jmp, do_miss;

  assign eligible = valid_q & run_q & ~park_q;
  assign full     = &valid_q;
  assign fire     = (|eligible) & ~bus.stall;
  // Halted after a kill of thread 0: nothing may be created until reset.
  assign spawn_ok = bus.spawn_req & ~full & ~halt_q;

  always_comb begin
    sel_trd = '0;
    rr_trd  = '0;
    if (MODE == 1) begin
      for (int i = N_TRD - 1; i >= 0; i--)
        if (eligible[i]) sel_trd = TRD_W'(i);
    end else begin
      // Scan downward in distance so the nearest eligible thread after last_q wins.
      for (int k = N_TRD; k >= 1; k--) begin
        rr_trd = TRD_W'((int'(last_q) + k) % N_TRD);
        if (eligible[rr_trd]) sel_trd = rr_trd;
      end
    end
  end

  always_comb begin
    free_id = '0;
    for (int i = N_TRD - 1; i >= 0; i--)
      if (!valid_q[i]) free_id = TRD_W'(i);
  end

  assign do_kill  = bus.kill & valid_q[bus.obj_trd];
  assign do_kill0 = do_kill & (bus.obj_trd == '0);
  assign do_sleep = bus.sleep & ~bus.kill & ~bus.wake;
  assign do_wake  = bus.wake & ~bus.kill & ~bus.sleep & valid_q[bus.obj_trd];
  assign do_jmp   = bus.jmp_en & valid_q[bus.jmp_trd];
  assign do_miss  = bus.miss_en & valid_q[bus.miss_trd];

  always_comb begin
    valid_d = valid_q;
    run_d   = run_q;
    park_d  = park_q;
    child_d = child_q;
    halt_d  = halt_q | do_kill0;
    of_d    = bus.spawn_req & full & ~halt_q;
    last_d  = fire ? sel_trd : last_q;
    for (int t = 0; t < N_TRD; t++) pc_d[t] = pc_q[t];

    for (int t = 0; t < N_TRD; t++) begin
      // Lowest-priority writers first so later assignments override them.
      if (fire && sel_trd == TRD_W'(t)) pc_d[t] = pc_q[t] + 32'd4;
      if (do_jmp && bus.jmp_trd == TRD_W'(t)) pc_d[t] = bus.jmp_pc;
      if (bus.miss_clr && bus.miss_clr_trd == TRD_W'(t)) park_d[t] = 1'b0;
      if (do_miss && bus.miss_trd == TRD_W'(t)) begin
        pc_d[t]   = bus.miss_pc;
        park_d[t] = 1'b1;
      end
      if (do_sleep && bus.obj_trd == TRD_W'(t)) run_d[t] = 1'b0;
      if (do_wake && bus.obj_trd == TRD_W'(t)) run_d[t] = 1'b1;
      if (spawn_ok && free_id == TRD_W'(t)) begin
        valid_d[t] = 1'b1;
        run_d[t]   = 1'b1;
        park_d[t]  = 1'b0;
        pc_d[t]    = bus.spawn_pc;
        for (int p = 0; p < N_TRD; p++)
          if (bus.spawn_parent == TRD_W'(p)) child_d[p*N_TRD + t] = 1'b1;
      end
      if (do_kill && bus.obj_trd == TRD_W'(t)) begin
        valid_d[t] = 1'b0;
        run_d[t]   = 1'b0;
        park_d[t]  = 1'b0;
        pc_d[t]    = '0;
        for (int p = 0; p < N_TRD; p++) begin
          child_d[p*N_TRD + t] = 1'b0;
          child_d[t*N_TRD + p] = 1'b0;
        end
      end
    end

    if (do_kill0) begin
      valid_d = '0;
      run_d   = '0;
      park_d  = '0;
      child_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= N_TRD'(1);
      run_q   <= N_TRD'(1);
      park_q  <= '0;
      child_q <= '0;
      last_q  <= TRD_W'(N_TRD - 1);
      of_q    <= 1'b0;
      halt_q  <= 1'b0;
      for (int t = 0; t < N_TRD; t++) pc_q[t] <= (t == 0) ? RESET_PC : 32'h0;
    end else begin
      valid_q <= valid_d;
      run_q   <= run_d;
      park_q  <= park_d;
      child_q <= child_d;
      last_q  <= last_d;
      of_q    <= of_d;
      halt_q  <= halt_d;
      for (int t = 0; t < N_TRD; t++) pc_q[t] <= pc_d[t];
    end
  end

  assign bus.if_vld     = |eligible;
  assign bus.if_trd     = sel_trd;
  assign bus.if_pc      = pc_q[sel_trd];
  assign bus.spawn_ok   = spawn_ok;
  assign bus.spawn_id   = free_id;
  assign bus.valid_trd  = valid_q;
  assign bus.run_trd    = run_q;
  assign bus.park_trd   = park_q;
  assign bus.child_mask = child_q;
  assign bus.trd_full   = full;
  assign bus.trd_of     = of_q;

endmodule

// File: tb/tb_thread_sched.sv
// tb/tb_thread_sched.sv - directed self-checking bench for thread_sched (round-robin and fixed-priority)
module tb_thread_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  thread_sched_if #(.N_TRD(8), .TRD_W(3)) b0 ();
  thread_sched_if #(.N_TRD(8), .TRD_W(3)) b1 ();

  thread_sched #(.N_TRD(8), .TRD_W(3), .RESET_PC(32'h0), .MODE(0)) d0 (.clk(clk), .rst(rst), .bus(b0));
  thread_sched #(.N_TRD(8), .TRD_W(3), .RESET_PC(32'h0), .MODE(1)) d1 (.clk(clk), .rst(rst), .bus(b1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b0.stall = 0; b0.jmp_en = 0; b0.jmp_trd = 0; b0.jmp_pc = 0;
    b0.miss_en = 0; b0.miss_trd = 0; b0.miss_pc = 0; b0.miss_clr = 0; b0.miss_clr_trd = 0;
    b0.spawn_req = 0; b0.spawn_pc = 0; b0.spawn_parent = 0;
    b0.kill = 0; b0.sleep = 0; b0.wake = 0; b0.obj_trd = 0;
    b1.stall = 0; b1.jmp_en = 0; b1.jmp_trd = 0; b1.jmp_pc = 0;
    b1.miss_en = 0; b1.miss_trd = 0; b1.miss_pc = 0; b1.miss_clr = 0; b1.miss_clr_trd = 0;
    b1.spawn_req = 0; b1.spawn_pc = 0; b1.spawn_parent = 0;
    b1.kill = 0; b1.sleep = 0; b1.wake = 0; b1.obj_trd = 0;
  endtask

  task automatic test_reset();
    rst = 1; step(); step(); rst = 0;
    checks++; if (b0.valid_trd !== 8'h01) begin errors++; $display("FAIL reset_valid got %h exp 01", b0.valid_trd); end
    checks++; if (b0.run_trd !== 8'h01) begin errors++; $display("FAIL reset_run got %h exp 01", b0.run_trd); end
    checks++; if (b0.park_trd !== 8'h00) begin errors++; $display("FAIL reset_park got %h exp 00", b0.park_trd); end
    checks++; if (b0.child_mask !== 64'h0) begin errors++; $display("FAIL reset_child got %h exp 0", b0.child_mask); end
    checks++; if (b0.trd_of !== 1'b0) begin errors++; $display("FAIL reset_of got %b exp 0", b0.trd_of); end
    checks++; if (b0.trd_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", b0.trd_full); end
    checks++; if (b0.spawn_id !== 3'd1) begin errors++; $display("FAIL reset_spawn_id got %0d exp 1", b0.spawn_id); end
    checks++; if (b0.if_vld !== 1'b1) begin errors++; $display("FAIL reset_if_vld got %b exp 1", b0.if_vld); end
  endtask

  task automatic test_fetch_single();
    for (int k = 0; k < 4; k++) begin
      checks++; if (b0.if_trd !== 3'd0) begin errors++; $display("FAIL fetch_trd[%0d] got %0d exp 0", k, b0.if_trd); end
      checks++; if (b0.if_pc !== 32'(4 * k)) begin errors++; $display("FAIL fetch_pc[%0d] got %h exp %h", k, b0.if_pc, 32'(4 * k)); end
      step();
    end
  endtask

  task automatic test_spawn_rr();
    logic [2:0]  exp_trd [4];
    logic [31:0] exp_pc [4];
    exp_trd[0] = 3'd1; exp_pc[0] = 32'h100;
    exp_trd[1] = 3'd2; exp_pc[1] = 32'h200;
    exp_trd[2] = 3'd0; exp_pc[2] = 32'h10;
    exp_trd[3] = 3'd1; exp_pc[3] = 32'h104;
    b0.stall = 1; b0.spawn_req = 1; b0.spawn_pc = 32'h100; b0.spawn_parent = 0;
    #1;
    checks++; if (b0.spawn_ok !== 1'b1) begin errors++; $display("FAIL spawn1_ok got %b exp 1", b0.spawn_ok); end
    checks++; if (b0.spawn_id !== 3'd1) begin errors++; $display("FAIL spawn1_id got %0d exp 1", b0.spawn_id); end
    step();
    b0.spawn_pc = 32'h200;
    #1;
    checks++; if (b0.spawn_id !== 3'd2) begin errors++; $display("FAIL spawn2_id got %0d exp 2", b0.spawn_id); end
    step();
    b0.spawn_req = 0; b0.stall = 0;
    #1;
    checks++; if (b0.child_mask[7:0] !== 8'h06) begin errors++; $display("FAIL child_row0 got %h exp 06", b0.child_mask[7:0]); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (b0.if_trd !== exp_trd[k]) begin errors++; $display("FAIL rr_trd[%0d] got %0d exp %0d", k, b0.if_trd, exp_trd[k]); end
      checks++; if (b0.if_pc !== exp_pc[k]) begin errors++; $display("FAIL rr_pc[%0d] got %h exp %h", k, b0.if_pc, exp_pc[k]); end
      step();
    end
  endtask

  task automatic test_miss();
    logic [2:0]  exp_trd [3];
    logic [31:0] exp_pc [3];
    exp_trd[0] = 3'd2; exp_pc[0] = 32'h204;
    exp_trd[1] = 3'd0; exp_pc[1] = 32'h14;
    exp_trd[2] = 3'd2; exp_pc[2] = 32'h208;
    b0.stall = 1; b0.miss_en = 1; b0.miss_trd = 1; b0.miss_pc = 32'h104;
    step();
    b0.miss_en = 0; b0.stall = 0;
    #1;
    checks++; if (b0.park_trd !== 8'h02) begin errors++; $display("FAIL miss_park got %h exp 02", b0.park_trd); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (b0.if_trd !== exp_trd[k]) begin errors++; $display("FAIL miss_skip_trd[%0d] got %0d exp %0d", k, b0.if_trd, exp_trd[k]); end
      checks++; if (b0.if_pc !== exp_pc[k]) begin errors++; $display("FAIL miss_skip_pc[%0d] got %h exp %h", k, b0.if_pc, exp_pc[k]); end
      step();
    end
    b0.stall = 1; b0.miss_clr = 1; b0.miss_clr_trd = 1;
    step();
    b0.miss_clr = 0; b0.stall = 0;
    #1;
    checks++; if (b0.park_trd !== 8'h00) begin errors++; $display("FAIL miss_clr_park got %h exp 00", b0.park_trd); end
    checks++; if (b0.if_trd !== 3'd0) begin errors++; $display("FAIL miss_clr_trd0 got %0d exp 0", b0.if_trd); end
    step();
    checks++; if (b0.if_trd !== 3'd1) begin errors++; $display("FAIL miss_resume_trd got %0d exp 1", b0.if_trd); end
    checks++; if (b0.if_pc !== 32'h104) begin errors++; $display("FAIL miss_resume_pc got %h exp 104", b0.if_pc); end
    step();
    b0.stall = 1; b0.miss_en = 1; b0.miss_trd = 1; b0.miss_pc = 32'h300; b0.miss_clr = 1; b0.miss_clr_trd = 1;
    step();
    b0.miss_en = 0; b0.miss_clr = 0;
    #1;
    checks++; if (b0.park_trd !== 8'h02) begin errors++; $display("FAIL miss_vs_clr_park got %h exp 02", b0.park_trd); end
    b0.miss_clr = 1; b0.miss_clr_trd = 1;
    step();
    b0.miss_clr = 0;
  endtask

  task automatic test_kill_jump();
    b0.stall = 1; b0.kill = 1; b0.obj_trd = 2; b0.jmp_en = 1; b0.jmp_trd = 2; b0.jmp_pc = 32'h500;
    step();
    b0.kill = 0; b0.jmp_en = 0;
    #1;
    checks++; if (b0.valid_trd !== 8'h03) begin errors++; $display("FAIL kill_valid got %h exp 03", b0.valid_trd); end
    checks++; if (b0.child_mask[7:0] !== 8'h02) begin errors++; $display("FAIL kill_col got %h exp 02", b0.child_mask[7:0]); end
    b0.spawn_req = 1; b0.spawn_pc = 32'h600; b0.spawn_parent = 0;
    #1;
    checks++; if (b0.spawn_id !== 3'd2) begin errors++; $display("FAIL reuse_id got %0d exp 2", b0.spawn_id); end
    step();
    b0.spawn_req = 0;
    b0.jmp_en = 1; b0.jmp_trd = 2; b0.jmp_pc = 32'h800;
    step();
    b0.jmp_en = 0; b0.stall = 0;
    #1;
    checks++; if (b0.if_trd !== 3'd2) begin errors++; $display("FAIL jmp_trd got %0d exp 2", b0.if_trd); end
    checks++; if (b0.if_pc !== 32'h800) begin errors++; $display("FAIL jmp_pc got %h exp 800", b0.if_pc); end
    b0.stall = 1;
    b0.kill = 1; b0.obj_trd = 2; b0.spawn_req = 1; b0.spawn_pc = 32'h700; b0.spawn_parent = 1;
    #1;
    checks++; if (b0.spawn_id !== 3'd3) begin errors++; $display("FAIL kill_spawn_id got %0d exp 3", b0.spawn_id); end
    step();
    b0.kill = 0; b0.spawn_req = 0;
    #1;
    checks++; if (b0.valid_trd !== 8'h0B) begin errors++; $display("FAIL kill_spawn_valid got %h exp 0b", b0.valid_trd); end
    checks++; if (b0.child_mask[15:8] !== 8'h08) begin errors++; $display("FAIL kill_spawn_row1 got %h exp 08", b0.child_mask[15:8]); end
    b0.wake = 1; b0.obj_trd = 2;
    step();
    b0.wake = 0;
    #1;
    checks++; if (b0.run_trd !== 8'h0B) begin errors++; $display("FAIL wake_invalid_run got %h exp 0b", b0.run_trd); end
    b0.sleep = 1; b0.obj_trd = 3;
    step();
    b0.sleep = 0;
    #1;
    checks++; if (b0.run_trd !== 8'h03) begin errors++; $display("FAIL sleep_run got %h exp 03", b0.run_trd); end
    b0.wake = 1; b0.obj_trd = 3;
    step();
    b0.wake = 0;
    #1;
    checks++; if (b0.run_trd !== 8'h0B) begin errors++; $display("FAIL wake_run got %h exp 0b", b0.run_trd); end
  endtask

  task automatic test_full();
    logic [2:0] exp_id [5];
    exp_id[0] = 3'd2; exp_id[1] = 3'd4; exp_id[2] = 3'd5; exp_id[3] = 3'd6; exp_id[4] = 3'd7;
    b0.stall = 1; b0.spawn_req = 1; b0.spawn_pc = 32'h900; b0.spawn_parent = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (b0.spawn_id !== exp_id[k]) begin errors++; $display("FAIL fill_id[%0d] got %0d exp %0d", k, b0.spawn_id, exp_id[k]); end
      step();
    end
    checks++; if (b0.valid_trd !== 8'hFF) begin errors++; $display("FAIL full_valid got %h exp ff", b0.valid_trd); end
    checks++; if (b0.trd_full !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", b0.trd_full); end
    checks++; if (b0.spawn_ok !== 1'b0) begin errors++; $display("FAIL full_spawn_ok got %b exp 0", b0.spawn_ok); end
    checks++; if (b0.trd_of !== 1'b0) begin errors++; $display("FAIL of_before got %b exp 0", b0.trd_of); end
    step();
    b0.spawn_req = 0;
    #1;
    checks++; if (b0.trd_of !== 1'b1) begin errors++; $display("FAIL of_pulse got %b exp 1", b0.trd_of); end
    checks++; if (b0.child_mask[7:0] !== 8'hF6) begin errors++; $display("FAIL of_child got %h exp f6", b0.child_mask[7:0]); end
    step();
    checks++; if (b0.trd_of !== 1'b0) begin errors++; $display("FAIL of_after got %b exp 0", b0.trd_of); end
  endtask

  task automatic test_kill0();
    b0.kill = 1; b0.obj_trd = 0;
    step();
    b0.kill = 0;
    #1;
    checks++; if (b0.valid_trd !== 8'h00) begin errors++; $display("FAIL kill0_valid got %h exp 00", b0.valid_trd); end
    checks++; if (b0.child_mask !== 64'h0) begin errors++; $display("FAIL kill0_child got %h exp 0", b0.child_mask); end
    checks++; if (b0.if_vld !== 1'b0) begin errors++; $display("FAIL kill0_if_vld got %b exp 0", b0.if_vld); end
    b0.spawn_req = 1;
    #1;
    checks++; if (b0.spawn_ok !== 1'b0) begin errors++; $display("FAIL kill0_spawn_ok got %b exp 0", b0.spawn_ok); end
    step();
    b0.spawn_req = 0;
    #1;
    checks++; if (b0.valid_trd !== 8'h00) begin errors++; $display("FAIL kill0_idle got %h exp 00", b0.valid_trd); end
  endtask

  task automatic test_reset_override();
    rst = 1; step(); rst = 0; b0.stall = 0;
    step();
    rst = 1; b0.jmp_en = 1; b0.jmp_trd = 0; b0.jmp_pc = 32'h44; b0.spawn_req = 1; b0.spawn_pc = 32'h88;
    step();
    rst = 0; b0.jmp_en = 0; b0.spawn_req = 0;
    #1;
    checks++; if (b0.valid_trd !== 8'h01) begin errors++; $display("FAIL rst_ovr_valid got %h exp 01", b0.valid_trd); end
    checks++; if (b0.if_pc !== 32'h0) begin errors++; $display("FAIL rst_ovr_pc got %h exp 0", b0.if_pc); end
  endtask

  task automatic test_fixed_prio();
    b1.stall = 1; b1.spawn_req = 1; b1.spawn_pc = 32'h100; b1.spawn_parent = 0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      checks++; if (b1.spawn_id !== 3'(k)) begin errors++; $display("FAIL prio_spawn_id[%0d] got %0d exp %0d", k, b1.spawn_id, k); end
      step();
    end
    b1.spawn_req = 0; b1.stall = 0;
    #1;
    checks++; if (b1.if_trd !== 3'd0) begin errors++; $display("FAIL prio_trd0 got %0d exp 0", b1.if_trd); end
    b1.stall = 1; b1.sleep = 1; b1.obj_trd = 0;
    step();
    b1.sleep = 0; b1.stall = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (b1.if_trd !== 3'd1) begin errors++; $display("FAIL prio_sleep_trd[%0d] got %0d exp 1", k, b1.if_trd); end
      checks++; if (b1.if_pc !== 32'h100 + 32'(4 * k)) begin errors++; $display("FAIL prio_sleep_pc[%0d] got %h exp %h", k, b1.if_pc, 32'h100 + 32'(4 * k)); end
      step();
    end
    b1.stall = 1; b1.wake = 1; b1.obj_trd = 0;
    step();
    b1.wake = 0; b1.stall = 0;
    #1;
    checks++; if (b1.if_trd !== 3'd0) begin errors++; $display("FAIL prio_wake_trd got %0d exp 0", b1.if_trd); end
    b1.stall = 1; b1.kill = 1; b1.sleep = 1; b1.obj_trd = 3;
    step();
    b1.kill = 0; b1.sleep = 0;
    #1;
    checks++; if (b1.valid_trd !== 8'h07) begin errors++; $display("FAIL prio_kill_sleep_valid got %h exp 07", b1.valid_trd); end
    checks++; if (b1.run_trd !== 8'h07) begin errors++; $display("FAIL prio_kill_sleep_run got %h exp 07", b1.run_trd); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fetch_single();
    test_spawn_rr();
    test_miss();
    test_kill_jump();
    test_full();
    test_kill0();
    test_reset_override();
    test_fixed_prio();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
